// File: rtl/sensor_scheduler_pkg.sv
// sensor_scheduler shared definitions:
// FSM state codes, ASCII constants and BCD-to-ASCII mapping.
package sensor_scheduler_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA         = 4'd1,
    DISPARA        = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    ARMAZENA       = 4'd4,
    ENVIA          = 4'd5,
    AGUARDA_TX     = 4'd6,
    PROXIMO        = 4'd7,
    FIM            = 4'd8
  } estado_t;

  localparam logic [6:0] ASC_ZERO  = 7'h30;
  localparam logic [6:0] ASC_HASH  = 7'h23;
  localparam logic [6:0] ASC_DASH  = 7'h2D;
  localparam logic [6:0] ASC_QUEST = 7'h3F;

  function automatic logic [6:0] bcd2ascii(
    input logic [3:0] d
  );
    return (d > 4'd9) ? ASC_QUEST
                      : ASC_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/sensor_scheduler_contador.sv
// contador_m: modulo-M counter with clear/enable
// and an end-of-count flag (count == M-1).
module contador_m #(
  parameter int M = 100,
  parameter int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  logic [N-1:0] r_q;
  logic         w_ult;

  assign w_ult = (r_q == N'(M - 1));
  assign o_fim = w_ult;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_q <= '0;
    end else if (i_zera) begin
      r_q <= '0;
    end else if (i_conta) begin
      r_q <= w_ult ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_scheduler.sv
// sensor_scheduler: triggers HC-SR04 measurements
// and sends the result as "d2 d1 d0 #" over serial.
module sensor_scheduler
  import sensor_scheduler_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 50_000_000,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        modo,
  output logic        medir_sensor,
  input  logic        sensor_pronto,
  input  logic [11:0] medida,
  output logic        tx_partida,
  output logic [6:0]  tx_dado,
  input  logic        tx_pronto,
  output logic [11:0] medida_reg,
  output logic        erro,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  estado_t     r_estado;
  estado_t     w_prox;
  logic        r_modo_ant;
  logic        r_pendente;
  logic        r_ok;
  logic        r_erro;
  logic [1:0]  r_indice;
  logic [11:0] r_cap;
  logic [11:0] r_medida_reg;
  logic [3:0]  w_digito;
  logic        w_per_zera;
  logic        w_per_fim;
  logic        w_tick;
  logic        w_to_fim;
  logic        w_req;

  assign w_per_zera = ~modo | (modo ^ r_modo_ant);
  assign w_tick     = w_per_fim & ~w_per_zera;
  assign w_req      = medir | w_tick;

  contador_m #(.M(PERIOD_CYCLES)) u_periodo (
    .i_clock (clock),
    .i_reset (reset),
    .i_zera  (w_per_zera),
    .i_conta (modo),
    .o_fim   (w_per_fim)
  );

  contador_m #(.M(TIMEOUT_CYCLES)) u_timeout (
    .i_clock (clock),
    .i_reset (reset),
    .i_zera  (r_estado == DISPARA),
    .i_conta (r_estado == AGUARDA_MEDIDA),
    .o_fim   (w_to_fim)
  );

  always_comb begin
    w_prox       = r_estado;
    medir_sensor = 1'b0;
    tx_partida   = 1'b0;
    pronto       = 1'b0;
    unique case (r_estado)
      INICIAL: w_prox = ESPERA;
      ESPERA:
        if (w_req | r_pendente) w_prox = DISPARA;
      DISPARA: begin
        medir_sensor = 1'b1;
        w_prox       = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA:
        if (sensor_pronto | w_to_fim) w_prox = ARMAZENA;
      ARMAZENA: w_prox = ENVIA;
      ENVIA: begin
        tx_partida = 1'b1;
        w_prox     = AGUARDA_TX;
      end
      AGUARDA_TX:
        if (tx_pronto) w_prox = PROXIMO;
      PROXIMO:
        w_prox = (r_indice < 2'd3) ? ENVIA : FIM;
      FIM: begin
        pronto = 1'b1;
        w_prox = ESPERA;
      end
      default: w_prox = INICIAL;
    endcase
  end

  // Result is captured when sensor_pronto is seen
  // and only committed to medida_reg in ARMAZENA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= INICIAL;
      r_modo_ant   <= 1'b0;
      r_pendente   <= 1'b0;
      r_ok         <= 1'b0;
      r_erro       <= 1'b0;
      r_indice     <= 2'd0;
      r_cap        <= 12'd0;
      r_medida_reg <= 12'd0;
    end else begin
      r_estado   <= w_prox;
      r_modo_ant <= modo;
      if (w_prox == DISPARA) begin
        r_pendente <= 1'b0;
      end else if (r_estado != ESPERA && w_req) begin
        r_pendente <= 1'b1;
      end
      if (r_estado == DISPARA) begin
        r_ok <= 1'b0;
      end
      if (r_estado == AGUARDA_MEDIDA && sensor_pronto) begin
        r_ok  <= 1'b1;
        r_cap <= medida;
      end
      if (r_estado == ARMAZENA) begin
        r_indice <= 2'd0;
        r_erro   <= ~r_ok;
        if (r_ok) r_medida_reg <= r_cap;
      end else if (r_estado == PROXIMO && r_indice < 2'd3) begin
        r_indice <= r_indice + 2'd1;
      end
    end
  end

  always_comb begin
    w_digito = r_medida_reg[3:0];
    unique case (r_indice)
      2'd0:    w_digito = r_medida_reg[11:8];
      2'd1:    w_digito = r_medida_reg[7:4];
      default: w_digito = r_medida_reg[3:0];
    endcase
    if (r_indice == 2'd3) tx_dado = ASC_HASH;
    else if (r_erro)      tx_dado = ASC_DASH;
    else                  tx_dado = bcd2ascii(w_digito);
  end

  assign medida_reg = r_medida_reg;
  assign erro       = r_erro;
  assign db_estado  = r_estado;

endmodule
